// File: rtl/btb_update_ctrl.sv
// BTB write-port scheduler: queues branch-resolution updates (hashed index stored at enqueue)
// and runs a set-by-set clear walk on flush requests.
module btb_update_ctrl #(
  parameter int BTB_INDEX_WIDTH                = 8,
  parameter int LOG_BTB_NWAY_ENTRIES_PER_BLOCK = 2,
  parameter int ASID_WIDTH                     = 9,
  parameter int BTB_ENTRY_WIDTH                = 40,
  parameter int UPD_FIFO_DEPTH                 = 4
) (
  input  logic                                      CLK,
  input  logic                                      RST,
  input  logic                                      upd_valid,
  output logic                                      upd_ready,
  input  logic [31:0]                               upd_PC,
  input  logic [ASID_WIDTH-1:0]                     upd_ASID,
  input  logic [BTB_ENTRY_WIDTH-1:0]                upd_payload,
  input  logic                                      flush_req,
  output logic                                      flush_busy,
  output logic                                      flush_done,
  output logic                                      btb_wr_valid,
  input  logic                                      btb_wr_ready,
  output logic                                      btb_wr_clear,
  output logic [BTB_INDEX_WIDTH-1:0]                btb_wr_index,
  output logic [LOG_BTB_NWAY_ENTRIES_PER_BLOCK-1:0] btb_wr_entry,
  output logic [BTB_ENTRY_WIDTH-1:0]                btb_wr_payload
);

  localparam int PTR_W  = $clog2(UPD_FIFO_DEPTH);
  localparam int IDX_LO = LOG_BTB_NWAY_ENTRIES_PER_BLOCK + 1;
  localparam int IDX_HI = BTB_INDEX_WIDTH + LOG_BTB_NWAY_ENTRIES_PER_BLOCK;
  localparam logic [BTB_INDEX_WIDTH-1:0] CNT_ONE = 1;
  localparam logic [PTR_W:0]             PTR_ONE = 1;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t                      state, state_next;
  logic [BTB_INDEX_WIDTH-1:0]  flush_cnt, flush_cnt_next;
  logic                        flush_done_next;
  logic                        fifo_discard;

  logic [BTB_INDEX_WIDTH-1:0]                fifo_index   [UPD_FIFO_DEPTH];
  logic [LOG_BTB_NWAY_ENTRIES_PER_BLOCK-1:0] fifo_entry   [UPD_FIFO_DEPTH];
  logic [BTB_ENTRY_WIDTH-1:0]                fifo_payload [UPD_FIFO_DEPTH];
  logic [PTR_W:0]                            wr_ptr, rd_ptr;
  logic                                      fifo_empty, fifo_full, enq, deq;

  logic [BTB_INDEX_WIDTH-1:0] asid_ext, hash_index;
  logic                       unused_pc_bits;

  // ASID is fitted to the index width before hashing
  generate
    if (ASID_WIDTH > BTB_INDEX_WIDTH) begin : g_asid_trunc
      logic unused_asid_bits;
      assign asid_ext         = upd_ASID[BTB_INDEX_WIDTH-1:0];
      assign unused_asid_bits = ^upd_ASID[ASID_WIDTH-1:BTB_INDEX_WIDTH];
    end else if (ASID_WIDTH == BTB_INDEX_WIDTH) begin : g_asid_same
      assign asid_ext = upd_ASID;
    end else begin : g_asid_ext
      assign asid_ext = {{(BTB_INDEX_WIDTH-ASID_WIDTH){1'b0}}, upd_ASID};
    end
  endgenerate

  assign hash_index     = upd_PC[IDX_HI:IDX_LO] ^ asid_ext;
  assign unused_pc_bits = ^{upd_PC[31:IDX_HI+1], upd_PC[0]};

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]) && (wr_ptr[PTR_W] != rd_ptr[PTR_W]);
  assign upd_ready  = !RST && !fifo_full && (state == IDLE) && !flush_req;
  assign enq        = upd_valid && upd_ready;
  assign deq        = (state == IDLE) && btb_wr_valid && btb_wr_ready;
  assign flush_busy = (state == FLUSH);

  always_comb begin
    state_next      = state;
    flush_cnt_next  = flush_cnt;
    flush_done_next = 1'b0;
    fifo_discard    = 1'b0;
    case (state)
      IDLE: begin
        if (flush_req) begin
          state_next     = FLUSH;
          flush_cnt_next = '0;
          fifo_discard   = 1'b1;
        end
      end
      FLUSH: begin
        // a new request restarts the walk and suppresses done for the aborted one
        if (flush_req) begin
          flush_cnt_next = '0;
        end else if (btb_wr_ready) begin
          flush_cnt_next = flush_cnt + CNT_ONE;
          if (flush_cnt == '1) begin
            state_next      = IDLE;
            flush_done_next = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    btb_wr_valid   = 1'b0;
    btb_wr_clear   = 1'b0;
    btb_wr_index   = fifo_index[rd_ptr[PTR_W-1:0]];
    btb_wr_entry   = fifo_entry[rd_ptr[PTR_W-1:0]];
    btb_wr_payload = fifo_payload[rd_ptr[PTR_W-1:0]];
    if (state == FLUSH) begin
      btb_wr_valid = 1'b1;
      btb_wr_clear = 1'b1;
      btb_wr_index = flush_cnt;
      btb_wr_entry = '0;
    end else begin
      btb_wr_valid = !fifo_empty && !flush_req;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      flush_cnt  <= '0;
      flush_done <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      state      <= state_next;
      flush_cnt  <= flush_cnt_next;
      flush_done <= flush_done_next;
      if (fifo_discard) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (enq) wr_ptr <= wr_ptr + PTR_ONE;
        if (deq) rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (enq) begin
      fifo_index[wr_ptr[PTR_W-1:0]]   <= hash_index;
      fifo_entry[wr_ptr[PTR_W-1:0]]   <= upd_PC[LOG_BTB_NWAY_ENTRIES_PER_BLOCK:1];
      fifo_payload[wr_ptr[PTR_W-1:0]] <= upd_payload;
    end
  end

endmodule

// File: tb/tb_btb_update_ctrl.sv
// Directed self-checking bench for btb_update_ctrl: hash, backpressure, flush walk,
// flush restart/stall and reset mid-flush.
module tb_btb_update_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        upd_valid;
  logic        upd_ready;
  logic [31:0] upd_PC;
  logic [8:0]  upd_ASID;
  logic [39:0] upd_payload;
  logic        flush_req;
  logic        flush_busy;
  logic        flush_done;
  logic        btb_wr_valid;
  logic        btb_wr_ready;
  logic        btb_wr_clear;
  logic [7:0]  btb_wr_index;
  logic [1:0]  btb_wr_entry;
  logic [39:0] btb_wr_payload;

  int checks = 0;
  int errors = 0;

  btb_update_ctrl dut (
    .CLK(CLK), .RST(RST),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_PC(upd_PC),
    .upd_ASID(upd_ASID), .upd_payload(upd_payload),
    .flush_req(flush_req), .flush_busy(flush_busy), .flush_done(flush_done),
    .btb_wr_valid(btb_wr_valid), .btb_wr_ready(btb_wr_ready), .btb_wr_clear(btb_wr_clear),
    .btb_wr_index(btb_wr_index), .btb_wr_entry(btb_wr_entry), .btb_wr_payload(btb_wr_payload)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [8:0] asid,
                               input logic [39:0] payload);
    upd_valid   = v;
    upd_PC      = pc;
    upd_ASID    = asid;
    upd_payload = payload;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    RST = 1'b1;
    flush_req = 1'b0;
    btb_wr_ready = 1'b1;
    applyStimulus(1'b0, 32'h0, 9'h0, 40'h0);
    tick();
    tick();
    settle();
    checkOutput("rst_upd_ready", upd_ready, 0);
    RST = 1'b0;
    settle();
    checkOutput("post_rst_upd_ready", upd_ready, 1);
    checkOutput("post_rst_wr_valid", btb_wr_valid, 0);
    checkOutput("post_rst_busy", flush_busy, 0);
    checkOutput("post_rst_done", flush_done, 0);

    // hash and latency
    applyStimulus(1'b1, 32'h0000_1238, 9'h005, 40'hAB_CDEF_0123);
    settle();
    checkOutput("no_bypass_valid", btb_wr_valid, 0);
    tick();
    applyStimulus(1'b0, 32'h0, 9'h0, 40'h0);
    settle();
    checkOutput("hash_valid", btb_wr_valid, 1);
    checkOutput("hash_index", btb_wr_index, 8'h42);
    checkOutput("hash_entry", btb_wr_entry, 2'h0);
    checkOutput("hash_clear", btb_wr_clear, 0);
    checkOutput("hash_payload", btb_wr_payload, 40'hAB_CDEF_0123);
    tick();
    settle();
    checkOutput("hash_drained", btb_wr_valid, 0);

    // ASID truncation
    applyStimulus(1'b1, 32'h0, 9'h1FF, 40'h55);
    tick();
    applyStimulus(1'b0, 32'h0, 9'h0, 40'h0);
    settle();
    checkOutput("trunc_index", btb_wr_index, 8'hFF);
    checkOutput("trunc_payload", btb_wr_payload, 40'h55);
    tick();

    // backpressure: 5 offered, 4 fit
    btb_wr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, (32'(i) << 3) | (32'(i % 4) << 1), 9'h0, 40'h100 + 40'(i));
      settle();
      checkOutput($sformatf("bp_ready_%0d", i), upd_ready, (i < 4) ? 1 : 0);
      tick();
    end
    applyStimulus(1'b0, 32'h0, 9'h0, 40'h0);
    settle();
    checkOutput("bp_hold_valid", btb_wr_valid, 1);
    checkOutput("bp_hold_index", btb_wr_index, 0);
    tick();
    settle();
    checkOutput("bp_hold_index2", btb_wr_index, 0);
    btb_wr_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      settle();
      checkOutput($sformatf("bp_valid_%0d", j), btb_wr_valid, 1);
      checkOutput($sformatf("bp_index_%0d", j), btb_wr_index, j);
      checkOutput($sformatf("bp_entry_%0d", j), btb_wr_entry, j);
      checkOutput($sformatf("bp_payload_%0d", j), btb_wr_payload, 40'h100 + 40'(j));
      checkOutput($sformatf("bp_upd_ready_%0d", j), upd_ready, (j == 0) ? 0 : 1);
      tick();
    end
    settle();
    checkOutput("bp_drained", btb_wr_valid, 0);

    // flush discards queued updates
    btb_wr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'h80 + (32'(i) << 3), 9'h0, 40'h200 + 40'(i));
      tick();
    end
    applyStimulus(1'b0, 32'h0, 9'h0, 40'h0);
    btb_wr_ready = 1'b1;
    flush_req = 1'b1;
    settle();
    checkOutput("freq_upd_ready", upd_ready, 0);
    checkOutput("freq_wr_valid", btb_wr_valid, 0);
    tick();
    flush_req = 1'b0;
    for (int c = 0; c < 256; c++) begin
      settle();
      checkOutput($sformatf("walk_valid_%0d", c), btb_wr_valid, 1);
      checkOutput($sformatf("walk_clear_%0d", c), btb_wr_clear, 1);
      checkOutput($sformatf("walk_index_%0d", c), btb_wr_index, c);
      checkOutput($sformatf("walk_entry_%0d", c), btb_wr_entry, 0);
      checkOutput($sformatf("walk_busy_%0d", c), flush_busy, 1);
      checkOutput($sformatf("walk_done_%0d", c), flush_done, 0);
      checkOutput($sformatf("walk_upd_ready_%0d", c), upd_ready, 0);
      tick();
    end
    settle();
    checkOutput("walk_done_pulse", flush_done, 1);
    checkOutput("walk_end_busy", flush_busy, 0);
    checkOutput("walk_discarded", btb_wr_valid, 0);
    checkOutput("walk_end_upd_ready", upd_ready, 1);
    tick();
    settle();
    checkOutput("walk_done_single", flush_done, 0);
    checkOutput("walk_still_empty", btb_wr_valid, 0);

    // restart at 0x80, then stall
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    for (int c = 0; c < 128; c++) tick();
    settle();
    checkOutput("restart_pre_index", btb_wr_index, 8'h80);
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    settle();
    checkOutput("restart_index", btb_wr_index, 8'h00);
    checkOutput("restart_busy", flush_busy, 1);
    tick();
    settle();
    checkOutput("restart_step", btb_wr_index, 8'h01);
    btb_wr_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      tick();
      settle();
      checkOutput($sformatf("stall_index_%0d", s), btb_wr_index, 8'h01);
      checkOutput($sformatf("stall_valid_%0d", s), btb_wr_valid, 1);
    end
    btb_wr_ready = 1'b1;
    tick();
    settle();
    checkOutput("stall_release", btb_wr_index, 8'h02);

    // reset mid-flush
    for (int c = 0; c < 14; c++) tick();
    settle();
    checkOutput("rmid_pre_index", btb_wr_index, 8'h10);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    settle();
    checkOutput("rmid_busy", flush_busy, 0);
    checkOutput("rmid_valid", btb_wr_valid, 0);
    checkOutput("rmid_done", flush_done, 0);
    checkOutput("rmid_upd_ready", upd_ready, 1);
    tick();
    settle();
    checkOutput("rmid_done_later", flush_done, 0);
    checkOutput("rmid_fifo_empty", btb_wr_valid, 0);

    // flush request coinciding with flush_done
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    for (int c = 0; c < 256; c++) tick();
    flush_req = 1'b1;
    settle();
    checkOutput("coinc_done", flush_done, 1);
    tick();
    flush_req = 1'b0;
    settle();
    checkOutput("coinc_busy", flush_busy, 1);
    checkOutput("coinc_index", btb_wr_index, 8'h00);
    checkOutput("coinc_done_off", flush_done, 0);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/btb_update_ctrl.md
Name: btb_update_ctrl

Overview:
Owns the single BTB write port and schedules all writes to it. It queues branch-resolution updates in a small FIFO and computes each update's BTB set index with the BTB index hash. It also runs a flush sequencer that walks every BTB set and clears it on context change or fence. The block sits between the branch-resolution and fence logic and the BTB array write port.

Parameters:
BTB_INDEX_WIDTH, 8, log2 number of BTB sets.
LOG_BTB_NWAY_ENTRIES_PER_BLOCK, 2, log2 entries per fetch block.
ASID_WIDTH, 9, ASID width.
BTB_ENTRY_WIDTH, 40, opaque entry payload width (tag, target, type).
UPD_FIFO_DEPTH, 4, update queue depth; must be a power of 2 and at least 2.

Ports:
CLK  in  1  clock.
RST  in  1  reset; synchronous, active-high.
upd_valid  in  1  update request.
upd_ready  out  1  update accepted when upd_valid and upd_ready are both high.
upd_PC  in  32  branch PC.
upd_ASID  in  ASID_WIDTH  ASID of the update.
upd_payload  in  BTB_ENTRY_WIDTH  entry contents.
flush_req  in  1  single-cycle flush request.
flush_busy  out  1  high while the flush walk is in progress.
flush_done  out  1  one-cycle pulse when the walk completes.
btb_wr_valid  out  1  write or clear issued to the BTB.
btb_wr_ready  in  1  BTB accepts the write this cycle.
btb_wr_clear  out  1  1 = clear all entries of the set; 0 = entry write.
btb_wr_index  out  BTB_INDEX_WIDTH  set index.
btb_wr_entry  out  LOG_BTB_NWAY_ENTRIES_PER_BLOCK  entry within the block.
btb_wr_payload  out  BTB_ENTRY_WIDTH  entry data; value is don't-care when btb_wr_clear is 1.

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous and active-high. While RST is high at a rising edge, all state clears.
- Reset values:
  - state = IDLE, FIFO empty, flush counter = 0.
  - btb_wr_valid = 0, flush_busy = 0, flush_done = 0.
  - upd_ready = 0 while RST is high, and 1 in the first cycle after reset deasserts.
- Index hash, computed at enqueue time and stored in the FIFO:
  - index = upd_PC[BTB_INDEX_WIDTH+LOG_BTB_NWAY_ENTRIES_PER_BLOCK : LOG_BTB_NWAY_ENTRIES_PER_BLOCK+1] XOR upd_ASID.
  - upd_ASID is truncated to BTB_INDEX_WIDTH bits if wider, or zero-extended if narrower.
  - entry = upd_PC[LOG_BTB_NWAY_ENTRIES_PER_BLOCK:1].
- upd_ready = !fifo_full && (state == IDLE) && !flush_req.
- FIFO: registered storage with pointers one bit wider than log2(UPD_FIFO_DEPTH).
  - full = pointers equal in address bits and differ in the wrap bit.
  - Enqueue and dequeue in the same cycle are legal when the FIFO is non-empty; the count is unchanged.
  - No enqueue-to-output bypass. An update accepted at edge t is presented on the write port no earlier than cycle t+1.
- State IDLE:
  - btb_wr_valid = !fifo_empty && !flush_req; fields are driven from the FIFO head with btb_wr_clear = 0.
  - The head dequeues on btb_wr_valid && btb_wr_ready.
  - btb_wr_ready low holds the head stable; outputs must not change while valid and not ready.
- Transition IDLE to FLUSH on flush_req:
  - FIFO contents are discarded at that edge (they belong to the pre-flush context).
  - Counter is set to 0.
  - No FIFO write is issued in the flush_req cycle.
- State FLUSH:
  - flush_busy = 1.
  - btb_wr_valid = 1, btb_wr_clear = 1, btb_wr_index = counter, btb_wr_entry = 0.
  - Counter increments on btb_wr_ready only.
  - When counter == all-ones and btb_wr_ready is high, the next state is IDLE, the counter wraps to 0, and flush_done is registered high for exactly one cycle (the first IDLE cycle).
  - With btb_wr_ready held high the walk takes exactly 2^BTB_INDEX_WIDTH cycles.
- flush_req during FLUSH: the walk restarts with the counter set to 0 at that edge. No flush_done is emitted for the aborted walk.
- flush_req in the same cycle as flush_done: a new FLUSH begins. flush_done still pulses.
- RST high mid-flush or with a non-empty FIFO: everything returns to reset values at that edge, with no flush_done.
- No update is lost once accepted, except through flush discard or reset.

Test Plan:
- Hash and latency (defaults): upd_PC = 0x00001238, upd_ASID = 0x005, btb_wr_ready = 1, accepted at edge t -> in cycle t+1, btb_wr_valid = 1, index = 0x42, entry = 0x0, clear = 0, payload matches.
- ASID truncation: upd_PC = 0x00000000, upd_ASID = 0x1FF -> index = 0xFF.
- Backpressure: hold btb_wr_ready = 0 and offer 5 back-to-back updates -> first 4 accepted, upd_ready = 0 on the 5th. Release btb_wr_ready -> 4 writes emerge in order, one per cycle, and upd_ready returns to 1 after the first dequeue.
- Flush discard: 3 updates queued with btb_wr_ready = 0, then flush_req pulse with btb_wr_ready = 1 -> the queued writes never appear. Clears for index 0..255 appear in 256 consecutive cycles, flush_done pulses on cycle 257, and upd_ready = 0 throughout.
- Flush restart and stall: flush_req again at counter = 0x80 -> the next clear index is 0x00. Dropping btb_wr_ready for 3 cycles holds the index.
- Reset mid-flush: RST high at counter = 0x10 -> next cycle flush_busy = 0, btb_wr_valid = 0, no flush_done, FIFO empty.
